trojan_sweep_checker: RTL and testbench
=======================================

TROJAN_SWEEP_CHECKER -- requirements
Module: trojan_sweep_checker

Interface
REQ-001 SHALL have parameter IN_W, default 10: stimulus width; the sweep covers vectors 0 .. 2^IN_W-1.
REQ-002 SHALL have parameter OUT_W, default 4: response width; OUT_W >= clog2(IN_W).
REQ-003 SHALL have parameter LAT, default 1: fixed DUT response latency in cycles; LAT >= 1.
REQ-004 SHALL have clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have start  input  1  one-cycle request to begin a sweep.
REQ-007 SHALL have dut_resp  input  OUT_W  DUT response to the stimulus issued LAT cycles earlier.
REQ-008 SHALL have stim  output  IN_W  current stimulus vector to the DUT under test.
REQ-009 SHALL have busy  output  1  high in RUN and DRAIN.
REQ-010 SHALL have done  output  1  high in DONE.
REQ-011 SHALL have pass  output  1  high in DONE when mismatch_cnt == 0.
REQ-012 SHALL have match_cnt and mismatch_cnt  output  IN_W each  compare result counters.
REQ-013 SHALL have first_fail_vec  output  IN_W  stimulus of the first mismatch; first_fail_vld  output  1  marks it valid.

Function
REQ-014 SHALL compute golden(v) = floor(log2(v)) zero-extended to OUT_W, for v >= 1.
REQ-015 SHALL exclude vector 0 from comparison, with no count change for it.
REQ-016 SHALL use FSM states IDLE, RUN, DRAIN and DONE.
REQ-017 SHALL move IDLE->RUN on start; stim = 0 in the first RUN cycle and increments by 1 each RUN cycle.
REQ-018 SHALL move RUN->DRAIN in the cycle after stim = 2^IN_W-1 is issued.
REQ-019 SHALL hold stim in DRAIN at the last value.
REQ-020 SHALL stay in DRAIN exactly LAT cycles, then move to DONE.
REQ-021 SHALL delay golden value, stimulus and compare-valid through a LAT-deep pipeline aligned to dut_resp.
REQ-022 SHALL compare dut_resp with the aligned golden value each cycle the delayed compare-valid is high.
REQ-023 SHALL increment match_cnt on equality and mismatch_cnt otherwise.
REQ-024 SHALL, on the first mismatch of a sweep, latch its delayed stimulus into first_fail_vec and set first_fail_vld.
REQ-025 SHALL NOT update first_fail_vec on later mismatches.
REQ-026 SHALL ignore start in RUN and DRAIN.
REQ-027 SHALL, on start in DONE, clear counters, first_fail_vld and pipeline valids, then enter RUN (restart).
REQ-028 SHALL keep counters wrap-free: max count 2^IN_W-1 fits in IN_W bits.
REQ-029 SHALL register all outputs; outputs hold their values in DONE until restart or reset.

Reset
REQ-030 SHALL, on rst, immediately force IDLE.
REQ-031 SHALL reset stim, match_cnt, mismatch_cnt and first_fail_vec to 0.
REQ-032 SHALL reset busy, done, pass, first_fail_vld and all pipeline valids to 0.
REQ-033 SHALL discard a sweep interrupted by rst mid-operation; the next start begins at vector 0 with cleared counters.

Configuration
REQ-034 SHALL, with TSD_EARLY_STOP_EN defined, move directly to DONE from RUN or DRAIN in the cycle after the first mismatch is registered.
REQ-035 SHALL, with TSD_EARLY_STOP_EN defined, discard in-flight responses; pass = 0 and mismatch_cnt = 1.
REQ-036 SHALL, without TSD_EARLY_STOP_EN, always complete the full sweep per REQ-018..REQ-020.

Verification (IN_W=10, OUT_W=4, LAT=1 unless stated)
REQ-037 SHALL cover: golden-model DUT, pulse start -> done after 1024+LAT+1 cycles; match_cnt=1023, mismatch_cnt=0, pass=1, first_fail_vld=0.
REQ-038 SHALL cover: trojan DUT returns 4'hF when v[3:0]=4'b1011 -> mismatch_cnt=64, match_cnt=959, first_fail_vec=11, pass=0.
REQ-039 SHALL cover: same trojan with TSD_EARLY_STOP_EN -> DONE two cycles after stim=11; mismatch_cnt=1, match_cnt=10, first_fail_vec=11.
REQ-040 SHALL cover: LAT=3 with a 3-stage-delayed golden DUT -> pass=1, match_cnt=1023, DRAIN lasts 3 cycles.
REQ-041 SHALL cover: rst asserted at stim=500 -> all outputs 0 asynchronously; subsequent start gives a clean full result per REQ-037.
REQ-042 SHALL cover: start pulsed during RUN at stim=200 -> ignored, stim continues 201; start in DONE -> counters clear, new sweep from 0.

Source files
------------

// File: rtl/trojan_sweep_checker.sv
// trojan_sweep_checker
//   Exhaustively sweeps a combinational DUT (expected function: floor(log2(v)))
//   over every IN_W-bit stimulus vector. It compares each response, which
//   arrives LAT cycles after its stimulus, against a golden value. It counts
//   matches and mismatches and latches the stimulus of the first mismatch.
//
//   Optional feature: define TSD_EARLY_STOP_EN to end the sweep (go to DONE)
//   on the first mismatch. In-flight responses are then discarded.
//
// Ports
//   clk             in   single clock, rising edge
//   rst             in   asynchronous active-high reset
//   start           in   one-cycle sweep request (honoured in IDLE and DONE)
//   dut_resp        in   [OUT_W] DUT response to the stimulus issued LAT cycles ago
//   stim            out  [IN_W]  current stimulus vector
//   busy            out  high in RUN and DRAIN
//   done            out  high in DONE
//   pass            out  high in DONE when no mismatch was seen
//   match_cnt       out  [IN_W]  matching compares this sweep
//   mismatch_cnt    out  [IN_W]  mismatching compares this sweep
//   first_fail_vec  out  [IN_W]  stimulus of the first mismatch
//   first_fail_vld  out  first_fail_vec is valid
module trojan_sweep_checker #(
  parameter int IN_W  = 10,
  parameter int OUT_W = 4,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OUT_W-1:0] dut_resp,
  output logic [IN_W-1:0]  stim,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [IN_W-1:0]  match_cnt,
  output logic [IN_W-1:0]  mismatch_cnt,
  output logic [IN_W-1:0]  first_fail_vec,
  output logic             first_fail_vld
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [IN_W-1:0] STIM_LAST = '1;
  localparam int              DRAIN_W   = $clog2(LAT + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_END = DRAIN_W'(LAT - 1);

  // Index of the highest set bit; vector 0 never reaches a compare.
  function automatic logic [OUT_W-1:0] golden(input logic [IN_W-1:0] v);
    golden = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (v[i]) golden = OUT_W'(i);
    end
  endfunction

  logic [1:0]         state, state_nxt;
  logic [DRAIN_W-1:0] drain_cnt, drain_nxt;
  logic [IN_W-1:0]    stim_nxt;
  logic [IN_W-1:0]    match_nxt, mismatch_nxt, ffvec_nxt;
  logic               ffvld_nxt;
  logic               restart;
  logic               in_vld;
  logic               cmp_vld, cmp_hit, cmp_miss, first_miss;

  // Stimulus/golden pipeline aligned to dut_resp; stage LAT-1 is the compare stage.
  logic [LAT-1:0]     pipe_vld;
  logic [OUT_W-1:0]   pipe_gold [LAT];
  logic [IN_W-1:0]    pipe_stim [LAT];

  assign in_vld = (state == RUN) && (stim != '0);

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    // Compares only count while a sweep is active; in DONE (including after an
    // early stop) any response still in flight is discarded.
    cmp_vld    = pipe_vld[LAT-1] && ((state == RUN) || (state == DRAIN));
    cmp_hit    = cmp_vld && (dut_resp == pipe_gold[LAT-1]);
    cmp_miss   = cmp_vld && (dut_resp != pipe_gold[LAT-1]);
    first_miss = cmp_miss && !first_fail_vld;

    state_nxt    = state;
    stim_nxt     = stim;
    drain_nxt    = drain_cnt;
    restart      = 1'b0;
    match_nxt    = match_cnt + IN_W'(cmp_hit);
    mismatch_nxt = mismatch_cnt + IN_W'(cmp_miss);
    ffvld_nxt    = first_fail_vld | cmp_miss;
    ffvec_nxt    = first_miss ? pipe_stim[LAT-1] : first_fail_vec;

    case (state)
      IDLE: begin
        if (start) restart = 1'b1;
      end
      RUN: begin
        if (stim == STIM_LAST) begin
          state_nxt = DRAIN;
          drain_nxt = '0;
        end else begin
          stim_nxt = stim + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_END) state_nxt = DONE;
        else                        drain_nxt = drain_cnt + 1'b1;
      end
      DONE: begin
        if (start) restart = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase

`ifdef TSD_EARLY_STOP_EN
    if (first_miss) state_nxt = DONE;
`else
`endif

    if (restart) begin
      state_nxt    = RUN;
      stim_nxt     = '0;
      match_nxt    = '0;
      mismatch_nxt = '0;
      ffvld_nxt    = 1'b0;
      ffvec_nxt    = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      drain_cnt      <= '0;
      stim           <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      match_cnt      <= '0;
      mismatch_cnt   <= '0;
      first_fail_vec <= '0;
      first_fail_vld <= 1'b0;
      pipe_vld       <= '0;
    end else begin
      state          <= state_nxt;
      drain_cnt      <= drain_nxt;
      stim           <= stim_nxt;
      busy           <= (state_nxt == RUN) || (state_nxt == DRAIN);
      done           <= (state_nxt == DONE);
      pass           <= (state_nxt == DONE) && (mismatch_nxt == '0);
      match_cnt      <= match_nxt;
      mismatch_cnt   <= mismatch_nxt;
      first_fail_vec <= ffvec_nxt;
      first_fail_vld <= ffvld_nxt;
      // Shift in the new valid; the cast drops the bit leaving the last stage.
      pipe_vld       <= restart ? '0 : LAT'({pipe_vld, in_vld});
    end
  end

  // NOTE: the pipeline payload is not reset; it is only ever used when the
  // matching valid bit is set, and those bits are reset.
  always_ff @(posedge clk) begin
    pipe_gold[0] <= golden(stim);
    pipe_stim[0] <= stim;
    for (int i = 1; i < LAT; i++) begin
      pipe_gold[i] <= pipe_gold[i-1];
      pipe_stim[i] <= pipe_stim[i-1];
    end
  end

endmodule

// File: tb/tb_trojan_sweep_checker.sv
// Testbench for trojan_sweep_checker. Two instances share clk/rst/start:
// one with LAT=1 and one with LAT=3. Each is driven by a modelled DUT with an
// optional trojan: response = tval when (v & tmask) == tpat, else floor(log2 v).
// Expected results come from a per-sweep reference loop over all vectors.
module tb_trojan_sweep_checker;

  localparam int IN_W  = 10;
  localparam int OUT_W = 4;
  localparam int NVEC  = 1 << IN_W;

  logic clk = 1'b0;
  logic rst;
  logic start;

  logic [OUT_W-1:0] resp1, resp3;
  logic [IN_W-1:0]  stim1, stim3, mc1, mc3, mmc1, mmc3, ffvec1, ffvec3;
  logic             busy1, busy3, done1, done3, pass1, pass3, ffv1, ffv3;

  trojan_sweep_checker #(.IN_W(IN_W), .OUT_W(OUT_W), .LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .dut_resp(resp1),
    .stim(stim1), .busy(busy1), .done(done1), .pass(pass1),
    .match_cnt(mc1), .mismatch_cnt(mmc1),
    .first_fail_vec(ffvec1), .first_fail_vld(ffv1)
  );

  trojan_sweep_checker #(.IN_W(IN_W), .OUT_W(OUT_W), .LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start), .dut_resp(resp3),
    .stim(stim3), .busy(busy3), .done(done3), .pass(pass3),
    .match_cnt(mc3), .mismatch_cnt(mmc3),
    .first_fail_vec(ffvec3), .first_fail_vld(ffv3)
  );

  always #5 clk = ~clk;

`ifdef TSD_EARLY_STOP_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  // Trojan configuration (changed only between sweeps).
  bit       troj_on;
  int       tmask, tpat;
  int       tval;

  int checks = 0;
  int errors = 0;

  function automatic int log2_ref(input int v);
    int x, g;
    x = v;
    g = 0;
    while (x > 1) begin
      x = x / 2;
      g++;
    end
    return g;
  endfunction

  function automatic logic [OUT_W-1:0] resp_of(input int v);
    if (troj_on && ((v & tmask) == tpat)) return OUT_W'(tval);
    return OUT_W'(log2_ref(v));
  endfunction

  // Modelled DUTs under test: 1-cycle and 3-cycle registered responses.
  logic [OUT_W-1:0] r3a, r3b;
  always @(posedge clk) begin
    resp1 <= resp_of(int'(stim1));
    r3a   <= resp_of(int'(stim3));
    r3b   <= r3a;
    resp3 <= r3b;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Per-sweep observation counters, updated every cycle by step().
  int ticks, busy1_n, busy3_n, done1_at, done3_at, stim_errs;

  task automatic step();
    @(posedge clk);
    #1;
    ticks++;
    if (busy1) busy1_n++;
    if (busy3) busy3_n++;
    if (done1 && done1_at == 0) done1_at = ticks;
    if (done3 && done3_at == 0) done3_at = ticks;
    if (busy1 && ticks <= NVEC && int'(stim1) != ticks - 1) stim_errs++;
  endtask

  task automatic begin_sweep();
    ticks = 0; busy1_n = 0; busy3_n = 0;
    done1_at = 0; done3_at = 0; stim_errs = 0;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference: outcome of one full sweep under the current trojan settings.
  task automatic model_sweep(output int m, output int mm, output int fvec);
    m = 0; mm = 0; fvec = 0;
    for (int v = 1; v < NVEC; v++) begin
      if (resp_of(v) == OUT_W'(log2_ref(v))) begin
        m++;
      end else begin
        if (mm == 0) fvec = v;
        mm++;
        if (EARLY) break;
      end
    end
  endtask

  task automatic check_inst(input string tag, input int lat, input int done_at,
                            input int busy_n, input logic [IN_W-1:0] mc,
                            input logic [IN_W-1:0] mmc, input logic [IN_W-1:0] fvec,
                            input logic fvld, input logic ps, input logic dn,
                            input int em, input int emm, input int efvec);
    int exp_done;
    // Full sweep: start edge + NVEC RUN cycles + LAT DRAIN cycles.
    // Early stop: DONE follows the mismatch compare (stim = efvec) by one edge.
    exp_done = (EARLY && emm > 0) ? efvec + 2 + lat : NVEC + lat + 1;
    check({tag, " done_cycle"}, done_at, exp_done);
    check({tag, " busy_cycles"}, busy_n, exp_done - 1);
    check({tag, " done"}, int'(dn), 1);
    check({tag, " match_cnt"}, int'(mc), em);
    check({tag, " mismatch_cnt"}, int'(mmc), emm);
    check({tag, " pass"}, int'(ps), int'(emm == 0));
    check({tag, " ff_vld"}, int'(fvld), int'(emm > 0));
    if (emm > 0) check({tag, " ff_vec"}, int'(fvec), efvec);
  endtask

  task automatic finish_sweep(input string tag);
    int em, emm, efvec;
    int guard;
    guard = 0;
    while ((done1_at == 0 || done3_at == 0) && guard < 4 * NVEC) begin
      step();
      guard++;
    end
    check({tag, " timeout"}, int'(done1_at == 0 || done3_at == 0), 0);
    model_sweep(em, emm, efvec);
    check({tag, " stim_seq"}, stim_errs, 0);
    check_inst({tag, "/L1"}, 1, done1_at, busy1_n, mc1, mmc1, ffvec1, ffv1,
               pass1, done1, em, emm, efvec);
    check_inst({tag, "/L3"}, 3, done3_at, busy3_n, mc3, mmc3, ffvec3, ffv3,
               pass3, done3, em, emm, efvec);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " stim"}, int'(stim1), 0);
    check({tag, " busy"}, int'(busy1), 0);
    check({tag, " done"}, int'(done1), 0);
    check({tag, " pass"}, int'(pass1), 0);
    check({tag, " match"}, int'(mc1), 0);
    check({tag, " mismatch"}, int'(mmc1), 0);
    check({tag, " ff_vec"}, int'(ffvec1), 0);
    check({tag, " ff_vld"}, int'(ffv1), 0);
    check({tag, " busy3"}, int'(busy3), 0);
    check({tag, " stim3"}, int'(stim3), 0);
  endtask

  task automatic wait_stim(input int target);
    int guard;
    guard = 0;
    while (int'(stim1) != target && guard < 2 * NVEC) begin
      step();
      guard++;
    end
    check("wait_stim timeout", int'(int'(stim1) != target), 0);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    troj_on = 1'b0;
    tmask   = 0; tpat = 0; tval = 0;
    #12;
    check_all_zero("reset");
    #10 rst = 1'b0;
    idle_cycles(2);
    check_all_zero("idle");

    // Golden DUT: clean full sweep.
    begin_sweep();
    finish_sweep("golden");

    // Fixed trojan: 4'hF whenever v[3:0] == 4'b1011.
    troj_on = 1'b1; tmask = 'hF; tpat = 'hB; tval = 'hF;
    idle_cycles(3);
    begin_sweep();
    finish_sweep("trojan_b");

    // Reset in the middle of a sweep, then a clean sweep.
    troj_on = 1'b0;
    idle_cycles(2);
    begin_sweep();
    wait_stim(500);
    #2 rst = 1'b1;
    #1;
    check_all_zero("midrst");
    idle_cycles(2);
    rst = 1'b0;
    idle_cycles(1);
    begin_sweep();
    finish_sweep("after_rst");

    // Start pulsed during RUN is ignored; start in DONE restarts.
    begin_sweep();
    wait_stim(200);
    start = 1'b1;
    step();
    start = 1'b0;
    check("ignore_start stim", int'(stim1), 201);
    check("ignore_start busy", int'(busy1), 1);
    finish_sweep("ignored_start");
    begin_sweep();
    check("restart stim", int'(stim1), 0);
    check("restart busy", int'(busy1), 1);
    check("restart done", int'(done1), 0);
    check("restart match", int'(mc1), 0);
    check("restart mismatch", int'(mmc1), 0);
    check("restart ff_vld", int'(ffv1), 0);
    finish_sweep("restarted");

    // Randomised trojans with random idle gaps between sweeps.
    for (int it = 0; it < 4; it++) begin
      troj_on = 1'b1;
      tmask   = ($urandom_range(1, NVEC - 1) & $urandom_range(1, NVEC - 1)) | (1 << $urandom_range(0, IN_W - 1));
      tpat    = int'($urandom) & tmask;
      tval    = $urandom_range(0, (1 << OUT_W) - 1);
      idle_cycles($urandom_range(0, 5));
      begin_sweep();
      finish_sweep($sformatf("rand%0d", it));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
